// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, sizes and state type for the 16-point FFT datapath
package fft_pkg;
  localparam int DATA_W = 16;
  localparam int N_PTS = 16;
  localparam int CNT_W = $clog2(N_PTS);
  localparam int FCNT_W = 8;
  typedef enum logic {IDLE, FILL} state_t;
endpackage

// File: rtl/sixteen_points_collector.sv
// sixteen_points_collector: assembles 16 serial samples into a parallel frame with a one-cycle en strobe
module sixteen_points_collector
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              clear,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic [DATA_W-1:0] x5,
  output logic [DATA_W-1:0] x6,
  output logic [DATA_W-1:0] x7,
  output logic [DATA_W-1:0] x8,
  output logic [DATA_W-1:0] x9,
  output logic [DATA_W-1:0] x10,
  output logic [DATA_W-1:0] x11,
  output logic [DATA_W-1:0] x12,
  output logic [DATA_W-1:0] x13,
  output logic [DATA_W-1:0] x14,
  output logic [DATA_W-1:0] x15,
  output logic              en,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PTS - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, widx;
  logic done, wr;
  // The last sample lands straight in the output bank, so col needs only 15 slots
  logic [DATA_W-1:0] col [N_PTS-1];
  logic [DATA_W-1:0] out [N_PTS];
  always_comb begin
    done = in_valid && !clear && cnt == LAST;
    wr = in_valid && !done;
    widx = clear ? '0 : cnt;
    cnt_n = clear ? CNT_W'(in_valid) : (in_valid ? cnt + 1'b1 : cnt);
    state_n = (cnt_n == '0) ? IDLE : FILL;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      en <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < N_PTS - 1; i++) col[i] <= '0;
      for (int i = 0; i < N_PTS; i++) out[i] <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      en <= done;
      if (wr) col[widx] <= din;
      if (done) begin
        for (int i = 0; i < N_PTS - 1; i++) out[i] <= col[i];
        out[N_PTS-1] <= din;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
  assign busy = state == FILL;
  assign x0 = out[0];
  assign x1 = out[1];
  assign x2 = out[2];
  assign x3 = out[3];
  assign x4 = out[4];
  assign x5 = out[5];
  assign x6 = out[6];
  assign x7 = out[7];
  assign x8 = out[8];
  assign x9 = out[9];
  assign x10 = out[10];
  assign x11 = out[11];
  assign x12 = out[12];
  assign x13 = out[13];
  assign x14 = out[14];
  assign x15 = out[15];
endmodule
